parametrik_yapay_zeka_hizlandiricisi: RTL and testbench
=======================================================

# parametrik_yapay_zeka_hizlandiricisi

Parametrised successor to the convolution unit in the X-extension AI block of the execute stage. It holds a weight buffer and a data buffer of configurable depth and runs the multiply-accumulate internally. It supports a variable-length RUN, a sliding-window (circular) mode for the data buffer, overflow flagging and optional saturation. It returns one scalar result per RUN to the execute pipeline.

## Interface
- VERI_W, 32: operand width; buffer entries and `sonuc_o` width.
- DERINLIK, 8: entries per buffer; power of two, ≥2.
- DOYURMA, 0: 0 = `sonuc_o` is the truncated low VERI_W bits; 1 = result saturates to the signed VERI_W range.

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- durdur_i  in  1  pipeline stall; freezes all state
- basla_i  in  1  command valid
- kontrol_i  in  3  command: 000 LD_W, 001 CLR_W, 010 LD_X, 011 CLR_X, 100 RUN; others are no-ops
- rs2_en_i  in  1  LD also writes `deger2_i`
- kayan_mod_i  in  1  data buffer sliding mode, sampled on LD_X
- deger1_i, deger2_i  in  VERI_W  load operands
- bitti_o  out  1  command complete
- sonuc_o  out  VERI_W  last RUN result
- w_sayisi_o, x_sayisi_o  out  $clog2(DERINLIK)+1  valid entry counts
- tasma_o  out  1  sticky: a load was dropped because a buffer was full

## Operation
- A command executes only in a cycle with basla_i=1 and durdur_i=0.
- **LD_W**
  - Writes `deger1_i` at index `w_sayisi`, then `deger2_i` at the next index if rs2_en_i=1.
  - Each written entry increments the count.
  - A write to a full buffer is dropped and sets tasma_o.
  - With one slot left and rs2_en_i=1: `deger1_i` is stored and `deger2_i` is dropped.
- **LD_X, kayan_mod_i=0:** same rules as LD_W on the data buffer.
- **LD_X, kayan_mod_i=1:**
  - When full, each new entry overwrites the oldest entry and the head pointer advances (wrap modulo DERINLIK).
  - The count saturates at DERINLIK.
  - tasma_o is not set.
- **CLR_W / CLR_X:** zero the matching count and pointers; buffer contents need not be zeroed. tasma_o clears on either CLR.
- **RUN**
  - n = min(w_sayisi, x_sayisi).
  - result = Σ x[k]·w[k] for k=0..n-1, signed.
  - x[k] is the k-th oldest data entry; w[k] is weight index k.
  - The accumulator is 2·VERI_W+$clog2(DERINLIK) bits, so it cannot overflow.
  - DOYURMA=0: sonuc_o = acc[VERI_W-1:0].
  - DOYURMA=1: sonuc_o = acc clamped to [−2^(VERI_W−1), 2^(VERI_W−1)−1].
- **FSM states: BOSTA, CARP, BITTI**
  - BOSTA → CARP on an executing RUN with n>0; index=0, acc=0.
  - BOSTA → BITTI on an executing RUN with n=0; acc=0.
  - CARP: on each non-stalled cycle, acc += x[idx]·w[idx] and idx++; go to BITTI after the n-th product.
  - BITTI: bitti_o=1 and sonuc_o is updated. Return to BOSTA in the first cycle with durdur_i=0.
  - Abort: in CARP or BITTI, if basla_i=0 or kontrol_i≠RUN, return to BOSTA next cycle. acc is discarded and sonuc_o is unchanged.
- **bitti_o:**
  - Asserted combinationally for any non-RUN command, including no-op codes.
  - For RUN, asserted only in BITTI.
  - 0 when basla_i=0.
- Buffer contents and counts are unchanged by RUN.

## Timing
- Reset values:
  - sonuc_o=0, counts=0, tasma_o=0, FSM=BOSTA, pointers=0.
  - bitti_o follows its combinational rule (0 unless a non-RUN command is present).
  - Reset takes effect immediately, mid-run included.
- Loads and clears take effect at the end of the executing cycle; counts are visible the next cycle.
- RUN issued in cycle 0 (n>0):
  - CARP occupies cycles 1..n.
  - bitti_o=1 and the new sonuc_o are visible in cycle n+1, assuming no stalls.
- RUN with n=0: bitti_o=1 in cycle 1 with sonuc_o=0.
- Each stalled cycle delays completion by exactly one cycle; acc and idx hold.
- Maximum RUN latency is DERINLIK+1 cycles.
- The pipeline holds basla_i and kontrol_i until it sees bitti_o=1 with durdur_i=0.

## Test plan
- LD_W(3,4,rs2), LD_X(5,6,rs2), RUN → bitti_o exactly 3 cycles after RUN issue; sonuc_o=39; counts 2/2.
- LD_W(7), LD_X(−2), RUN → sonuc_o=0xFFFFFFF2.
- DERINLIK=8, weights 1×8; load data 1..10 as five LD_X pairs:
  - kayan_mod=1 → sonuc_o=52, x_sayisi_o=8, tasma_o=0.
  - kayan_mod=0 → sonuc_o=36, tasma_o=1.
  - CLR_X → tasma_o=0.
- x=w=0x7FFFFFFF:
  - DOYURMA=0 → sonuc_o=0x00000001.
  - DOYURMA=1 → sonuc_o=0x7FFFFFFF.
- 4-pair RUN with durdur_i high for 3 cycles mid-CARP → bitti_o at cycle 8, same result.
- 4-pair RUN; drop basla_i in CARP → FSM returns to BOSTA, sonuc_o keeps its old value.
- After CLR_W, RUN → bitti_o at cycle 1 with sonuc_o=0.
- Assert rst_i mid-CARP → all outputs 0 in the same cycle; subsequent RUN gives sonuc_o=0.

Source files
------------

// File: rtl/parametrik_yapay_zeka_hizlandiricisi_if.sv
// Command/result bus between the execute pipeline and the parametrised AI accelerator.
// The master is the pipeline; the slave is the accelerator.
interface parametrik_yapay_zeka_hizlandiricisi_if #(
  parameter int VERI_W   = 32,
  parameter int DERINLIK = 8
);
  localparam int SAY_W = $clog2(DERINLIK) + 1;

  logic              durdur_i;
  logic              basla_i;
  logic [2:0]        kontrol_i;
  logic              rs2_en_i;
  logic              kayan_mod_i;
  logic [VERI_W-1:0] deger1_i;
  logic [VERI_W-1:0] deger2_i;
  logic              bitti_o;
  logic [VERI_W-1:0] sonuc_o;
  logic [SAY_W-1:0]  w_sayisi_o;
  logic [SAY_W-1:0]  x_sayisi_o;
  logic              tasma_o;

  modport master (
    output durdur_i, basla_i, kontrol_i, rs2_en_i, kayan_mod_i, deger1_i, deger2_i,
    input  bitti_o, sonuc_o, w_sayisi_o, x_sayisi_o, tasma_o
  );

  modport slave (
    input  durdur_i, basla_i, kontrol_i, rs2_en_i, kayan_mod_i, deger1_i, deger2_i,
    output bitti_o, sonuc_o, w_sayisi_o, x_sayisi_o, tasma_o
  );
endinterface

// File: rtl/parametrik_yapay_zeka_hizlandiricisi.sv
// Weight/data buffers with an internal sequential multiply-accumulate.
// One product is accumulated per cycle; the data buffer can run as a sliding window.
module parametrik_yapay_zeka_hizlandiricisi #(
  parameter int VERI_W   = 32,
  parameter int DERINLIK = 8,
  parameter int DOYURMA  = 0
) (
  input logic clk_i,
  input logic rst_i,
  parametrik_yapay_zeka_hizlandiricisi_if.slave bus
);
  localparam int AW    = $clog2(DERINLIK);
  localparam int CW    = AW + 1;
  localparam int ACC_W = 2 * VERI_W + AW;

  localparam logic [CW-1:0] DOLU = CW'(DERINLIK);
  localparam logic [2:0] K_LDW  = 3'b000;
  localparam logic [2:0] K_CLRW = 3'b001;
  localparam logic [2:0] K_LDX  = 3'b010;
  localparam logic [2:0] K_CLRX = 3'b011;
  localparam logic [2:0] K_RUN  = 3'b100;

  localparam logic signed [ACC_W-1:0] UST = {{(ACC_W-VERI_W+1){1'b0}}, {(VERI_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ALT = {{(ACC_W-VERI_W+1){1'b1}}, {(VERI_W-1){1'b0}}};

  typedef enum logic [1:0] {BOSTA, CARP, BITTI} durum_t;

  logic [VERI_W-1:0] w_mem [DERINLIK];
  logic [VERI_W-1:0] x_mem [DERINLIK];

  logic [CW-1:0] w_say, x_say;
  logic [AW-1:0] x_bas;
  logic          tasma;

  durum_t                   durum;
  logic [AW-1:0]            idx;
  logic [CW-1:0]            n_reg;
  logic signed [ACC_W-1:0]  acc;
  logic [VERI_W-1:0]        sonuc;

  logic calis, run_tut;
  assign calis   = bus.basla_i & ~bus.durdur_i;
  assign run_tut = bus.basla_i & (bus.kontrol_i == K_RUN);

  logic          w_we1, w_we2, w_tas;
  logic [AW-1:0] w_i1, w_i2;
  logic [CW-1:0] w_say_n;

  always_comb begin
    w_we1   = 1'b0;
    w_we2   = 1'b0;
    w_tas   = 1'b0;
    w_i1    = '0;
    w_i2    = '0;
    w_say_n = w_say;
    if (w_say < DOLU) begin
      w_we1   = 1'b1;
      w_i1    = w_say[AW-1:0];
      w_say_n = w_say + 1'b1;
    end else begin
      w_tas = 1'b1;
    end
    if (bus.rs2_en_i) begin
      if (w_say_n < DOLU) begin
        w_we2   = 1'b1;
        w_i2    = w_say_n[AW-1:0];
        w_say_n = w_say_n + 1'b1;
      end else begin
        w_tas = 1'b1;
      end
    end
  end

  // Data buffer is circular from x_bas; when full in sliding mode the oldest entry is overwritten.
  logic          x_we1, x_we2, x_tas;
  logic [AW-1:0] x_i1, x_i2, x_bas_n;
  logic [CW-1:0] x_say_n;

  always_comb begin
    x_we1   = 1'b0;
    x_we2   = 1'b0;
    x_tas   = 1'b0;
    x_i1    = '0;
    x_i2    = '0;
    x_say_n = x_say;
    x_bas_n = x_bas;
    if (x_say < DOLU) begin
      x_we1   = 1'b1;
      x_i1    = x_bas + x_say[AW-1:0];
      x_say_n = x_say + 1'b1;
    end else if (bus.kayan_mod_i) begin
      x_we1   = 1'b1;
      x_i1    = x_bas;
      x_bas_n = x_bas + 1'b1;
    end else begin
      x_tas = 1'b1;
    end
    if (bus.rs2_en_i) begin
      if (x_say_n < DOLU) begin
        x_we2   = 1'b1;
        x_i2    = x_bas_n + x_say_n[AW-1:0];
        x_say_n = x_say_n + 1'b1;
      end else if (bus.kayan_mod_i) begin
        x_we2   = 1'b1;
        x_i2    = x_bas_n;
        x_bas_n = x_bas_n + 1'b1;
      end else begin
        x_tas = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (calis && bus.kontrol_i == K_LDW) begin
      if (w_we1) w_mem[w_i1] <= bus.deger1_i;
      if (w_we2) w_mem[w_i2] <= bus.deger2_i;
    end
    if (calis && bus.kontrol_i == K_LDX) begin
      if (x_we1) x_mem[x_i1] <= bus.deger1_i;
      if (x_we2) x_mem[x_i2] <= bus.deger2_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_say <= '0;
      x_say <= '0;
      x_bas <= '0;
      tasma <= 1'b0;
    end else if (calis) begin
      case (bus.kontrol_i)
        K_LDW: begin
          w_say <= w_say_n;
          if (w_tas) tasma <= 1'b1;
        end
        K_CLRW: begin
          w_say <= '0;
          tasma <= 1'b0;
        end
        K_LDX: begin
          x_say <= x_say_n;
          x_bas <= x_bas_n;
          if (x_tas) tasma <= 1'b1;
        end
        K_CLRX: begin
          x_say <= '0;
          x_bas <= '0;
          tasma <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  logic [CW-1:0]             n_comb;
  logic [VERI_W-1:0]         x_oku, w_oku;
  logic signed [2*VERI_W-1:0] carpim;
  logic signed [ACC_W-1:0]   acc_ek, acc_yeni;
  logic [VERI_W-1:0]         doymus;

  assign n_comb   = (w_say < x_say) ? w_say : x_say;
  assign x_oku    = x_mem[x_bas + idx];
  assign w_oku    = w_mem[idx];
  assign carpim   = $signed(x_oku) * $signed(w_oku);
  assign acc_ek   = {{AW{carpim[2*VERI_W-1]}}, carpim};
  assign acc_yeni = acc + acc_ek;

  always_comb begin
    doymus = acc_yeni[VERI_W-1:0];
    if (DOYURMA != 0) begin
      if (acc_yeni > UST)      doymus = UST[VERI_W-1:0];
      else if (acc_yeni < ALT) doymus = ALT[VERI_W-1:0];
    end
  end

  // A stall freezes the sequencer entirely, including a pending abort.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum <= BOSTA;
      idx   <= '0;
      n_reg <= '0;
      acc   <= '0;
      sonuc <= '0;
    end else if (!bus.durdur_i) begin
      case (durum)
        BOSTA: begin
          if (run_tut) begin
            idx   <= '0;
            acc   <= '0;
            n_reg <= n_comb;
            if (n_comb == '0) begin
              durum <= BITTI;
              sonuc <= '0;
            end else begin
              durum <= CARP;
            end
          end
        end
        CARP: begin
          if (!run_tut) begin
            durum <= BOSTA;
          end else begin
            acc <= acc_yeni;
            idx <= idx + 1'b1;
            if ({1'b0, idx} == n_reg - 1'b1) begin
              durum <= BITTI;
              sonuc <= doymus;
            end
          end
        end
        BITTI:   durum <= BOSTA;
        default: durum <= BOSTA;
      endcase
    end
  end

  assign bus.bitti_o    = bus.basla_i & ((bus.kontrol_i != K_RUN) | (durum == BITTI));
  assign bus.sonuc_o    = sonuc;
  assign bus.w_sayisi_o = w_say;
  assign bus.x_sayisi_o = x_say;
  assign bus.tasma_o    = tasma;
endmodule

// File: tb/tb_parametrik_yapay_zeka_hizlandiricisi.sv
// Directed bench: a truncating and a saturating instance driven with identical commands.
module tb_parametrik_yapay_zeka_hizlandiricisi;
  localparam logic [2:0] K_LDW  = 3'b000;
  localparam logic [2:0] K_CLRW = 3'b001;
  localparam logic [2:0] K_LDX  = 3'b010;
  localparam logic [2:0] K_CLRX = 3'b011;
  localparam logic [2:0] K_RUN  = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  parametrik_yapay_zeka_hizlandiricisi_if #(.VERI_W(32), .DERINLIK(8)) bus0 ();
  parametrik_yapay_zeka_hizlandiricisi_if #(.VERI_W(32), .DERINLIK(8)) bus1 ();

  assign bus1.durdur_i    = bus0.durdur_i;
  assign bus1.basla_i     = bus0.basla_i;
  assign bus1.kontrol_i   = bus0.kontrol_i;
  assign bus1.rs2_en_i    = bus0.rs2_en_i;
  assign bus1.kayan_mod_i = bus0.kayan_mod_i;
  assign bus1.deger1_i    = bus0.deger1_i;
  assign bus1.deger2_i    = bus0.deger2_i;

  parametrik_yapay_zeka_hizlandiricisi #(.VERI_W(32), .DERINLIK(8), .DOYURMA(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0)
  );
  parametrik_yapay_zeka_hizlandiricisi #(.VERI_W(32), .DERINLIK(8), .DOYURMA(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One non-RUN command for a single cycle; bitti_o must be high while it is presented.
  task automatic applyStimulus(input logic [2:0] k, input logic [31:0] d1, input logic [31:0] d2,
                               input logic rs2, input logic kayan);
    bus0.basla_i     = 1'b1;
    bus0.kontrol_i   = k;
    bus0.deger1_i    = d1;
    bus0.deger2_i    = d2;
    bus0.rs2_en_i    = rs2;
    bus0.kayan_mod_i = kayan;
    @(negedge clk);
    if (bus0.bitti_o !== 1'b1) checkOutput("bitti_cmd", {63'd0, bus0.bitti_o}, 64'd1);
    @(posedge clk);
    #1;
    bus0.basla_i = 1'b0;
  endtask

  // RUN held until bitti_o with no stall; latency counted from the issue cycle.
  task automatic run_komut(input string tag, input int stall_bas, input int stall_uz,
                           input int bek_cyc, input logic [31:0] bek_sonuc);
    int cyc;
    logic [31:0] son;
    cyc = -1;
    son = 32'hDEADBEEF;
    bus0.basla_i   = 1'b1;
    bus0.kontrol_i = K_RUN;
    for (int c = 0; c < 40; c++) begin
      bus0.durdur_i = (c >= stall_bas) && (c < stall_bas + stall_uz);
      @(negedge clk);
      if (bus0.bitti_o && !bus0.durdur_i) begin
        cyc = c;
        son = bus0.sonuc_o;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_lat"}, 64'(cyc), 64'(bek_cyc));
    checkOutput({tag, "_sonuc"}, {32'd0, son}, {32'd0, bek_sonuc});
    @(posedge clk);
    #1;
    bus0.basla_i  = 1'b0;
    bus0.durdur_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus0.durdur_i    = 1'b0;
    bus0.basla_i     = 1'b0;
    bus0.kontrol_i   = 3'b000;
    bus0.rs2_en_i    = 1'b0;
    bus0.kayan_mod_i = 1'b0;
    bus0.deger1_i    = '0;
    bus0.deger2_i    = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_sonuc", {32'd0, bus0.sonuc_o}, 64'd0);
    checkOutput("rst_wsay", {60'd0, bus0.w_sayisi_o}, 64'd0);
    checkOutput("rst_xsay", {60'd0, bus0.x_sayisi_o}, 64'd0);
    checkOutput("rst_tasma", {63'd0, bus0.tasma_o}, 64'd0);
    checkOutput("rst_bitti", {63'd0, bus0.bitti_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic 2-pair dot product: 3*5 + 4*6
    applyStimulus(K_LDW, 32'd3, 32'd4, 1'b1, 1'b0);
    applyStimulus(K_LDX, 32'd5, 32'd6, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t1_wsay", {60'd0, bus0.w_sayisi_o}, 64'd2);
    checkOutput("t1_xsay", {60'd0, bus0.x_sayisi_o}, 64'd2);
    @(posedge clk);
    #1;
    run_komut("t1", 99, 0, 3, 32'd39);
    checkOutput("t1_sat_sonuc", {32'd0, bus1.sonuc_o}, 64'd39);

    // Signed single product 7 * -2
    applyStimulus(K_CLRW, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_CLRX, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_LDW, 32'd7, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_LDX, 32'hFFFFFFFE, 32'd0, 1'b0, 1'b0);
    run_komut("t2", 99, 0, 2, 32'hFFFFFFF2);

    // Weights all 1; the last LD_W has one slot left so its second operand is dropped
    applyStimulus(K_CLRW, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_CLRX, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(K_LDW, 32'd1, 32'd1, 1'b1, 1'b0);
    applyStimulus(K_LDW, 32'd1, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_LDW, 32'd1, 32'd9, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("slot_wsay", {60'd0, bus0.w_sayisi_o}, 64'd8);
    checkOutput("slot_tasma", {63'd0, bus0.tasma_o}, 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(K_CLRX, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("clrx_tasma", {63'd0, bus0.tasma_o}, 64'd0);
    @(posedge clk);
    #1;

    // Sliding window over 1..10 keeps 3..10
    for (int i = 0; i < 5; i++)
      applyStimulus(K_LDX, 32'(2 * i + 1), 32'(2 * i + 2), 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("kay_xsay", {60'd0, bus0.x_sayisi_o}, 64'd8);
    checkOutput("kay_tasma", {63'd0, bus0.tasma_o}, 64'd0);
    @(posedge clk);
    #1;
    run_komut("kay", 99, 0, 9, 32'd52);

    // Non-sliding keeps 1..8 and flags the drop
    applyStimulus(K_CLRX, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(K_LDX, 32'(2 * i + 1), 32'(2 * i + 2), 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("sabit_tasma", {63'd0, bus0.tasma_o}, 64'd1);
    @(posedge clk);
    #1;
    run_komut("sabit", 99, 0, 9, 32'd36);
    applyStimulus(K_CLRX, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("clr_tasma", {63'd0, bus0.tasma_o}, 64'd0);
    @(posedge clk);
    #1;

    // Truncation versus saturation of 0x7FFFFFFF squared
    applyStimulus(K_CLRW, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_LDW, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_LDX, 32'h7FFFFFFF, 32'd0, 1'b0, 1'b0);
    run_komut("trunc", 99, 0, 2, 32'h00000001);
    checkOutput("doyma_sonuc", {32'd0, bus1.sonuc_o}, 64'h7FFFFFFF);

    // Four pairs with a 3-cycle stall inside CARP: 5+12+21+32
    applyStimulus(K_CLRW, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_CLRX, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_LDW, 32'd1, 32'd2, 1'b1, 1'b0);
    applyStimulus(K_LDW, 32'd3, 32'd4, 1'b1, 1'b0);
    applyStimulus(K_LDX, 32'd5, 32'd6, 1'b1, 1'b0);
    applyStimulus(K_LDX, 32'd7, 32'd8, 1'b1, 1'b0);
    run_komut("stall", 2, 3, 8, 32'd70);

    // Abort mid-CARP keeps the old result; a fresh RUN then restarts from BOSTA
    applyStimulus(K_CLRW, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(K_LDW, 32'd2, 32'd2, 1'b1, 1'b0);
    applyStimulus(K_LDW, 32'd2, 32'd2, 1'b1, 1'b0);
    bus0.basla_i   = 1'b1;
    bus0.kontrol_i = K_RUN;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus0.basla_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_sonuc", {32'd0, bus0.sonuc_o}, 64'd70);
    end
    @(posedge clk);
    #1;
    run_komut("yeniden", 99, 0, 5, 32'd52);

    // Empty weight buffer: immediate completion with zero
    applyStimulus(K_CLRW, 32'd0, 32'd0, 1'b0, 1'b0);
    run_komut("bos", 99, 0, 1, 32'd0);
    checkOutput("bos_xsay", {60'd0, bus0.x_sayisi_o}, 64'd4);

    // Asynchronous reset in the middle of CARP
    applyStimulus(K_LDW, 32'd1, 32'd1, 1'b1, 1'b0);
    applyStimulus(K_LDW, 32'd1, 32'd1, 1'b1, 1'b0);
    run_komut("onrst", 99, 0, 5, 32'd26);
    bus0.basla_i   = 1'b1;
    bus0.kontrol_i = K_RUN;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_sonuc", {32'd0, bus0.sonuc_o}, 64'd0);
    checkOutput("arst_wsay", {60'd0, bus0.w_sayisi_o}, 64'd0);
    checkOutput("arst_xsay", {60'd0, bus0.x_sayisi_o}, 64'd0);
    checkOutput("arst_bitti", {63'd0, bus0.bitti_o}, 64'd0);
    bus0.basla_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_komut("sonrst", 99, 0, 1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
